// File: rtl/bus_arbiter_pkg.sv
// Shared owner encoding and grant decode for the four-master bus arbiter.
package bus_arbiter_pkg;

  localparam int BUS_OWNER_W     = 2;
  localparam int BUS_NUM_MASTERS = 4;

  typedef enum logic [BUS_OWNER_W-1:0] {
    BUS_OWNER_MASTER_0 = 2'd0,
    BUS_OWNER_MASTER_1 = 2'd1,
    BUS_OWNER_MASTER_2 = 2'd2,
    BUS_OWNER_MASTER_3 = 2'd3
  } bus_owner_e;

  // Active-low one-cold grant vector for the given owner.
  function automatic logic [BUS_NUM_MASTERS-1:0] bus_owner_grant_n(input bus_owner_e owner);
    logic [BUS_NUM_MASTERS-1:0] g;
    g = '1;
    g[owner] = 1'b0;
    return g;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Rotating search for the next requester after the current owner; the owner
// itself is never a candidate.
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  bus_owner_e                 owner_i,
  input  logic [BUS_NUM_MASTERS-1:0] req_n_i,
  output bus_owner_e                 next_owner_o,
  output logic                       valid_o
);

  logic [BUS_OWNER_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    next_owner_o = owner_i;
    valid_o      = 1'b0;
    cand         = '0;
    for (int k = BUS_NUM_MASTERS - 1; k >= 1; k--) begin
      cand = owner_i + 2'(k);
      if (!req_n_i[cand]) begin
        next_owner_o = bus_owner_e'(cand);
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four active-low bus masters with registered ownership.
// Optional hold watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req_,
  input  logic m1_req_,
  input  logic m2_req_,
  input  logic m3_req_,
  output logic m0_grnt_,
  output logic m1_grnt_,
  output logic m2_grnt_,
  output logic m3_grnt_,
  output logic bus_timeout
);

  logic [BUS_NUM_MASTERS-1:0] reqN;
  logic [BUS_NUM_MASTERS-1:0] ownerMask;
  logic                       ownerReq;
  logic                       othersWait;
  bus_owner_e                 owner_q, owner_d;
  bus_owner_e                 pickOwner;
  logic                       pickValid;

  assign reqN       = {m3_req_, m2_req_, m1_req_, m0_req_};
  assign ownerMask  = ~bus_owner_grant_n(owner_q);
  assign ownerReq   = ~reqN[owner_q];
  assign othersWait = |(~reqN & ~ownerMask);

  bus_arb_rr_pick u_pick (
    .owner_i      (owner_q),
    .req_n_i      (reqN),
    .next_owner_o (pickOwner),
    .valid_o      (pickValid)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Release hands over to the next requester; while holding, the watchdog
  // counts cycles in which someone else waits and forces a handover on expiry.
  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (!ownerReq) begin
      if (pickValid) begin
        owner_d = pickOwner;
      end
      cnt_d = '0;
    end else if (!othersWait) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
      owner_d   = pickOwner;
      cnt_d     = '0;
      timeout_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= BUS_OWNER_MASTER_0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  // Without the watchdog the owner keeps the bus for as long as it requests.
  always_comb begin
    owner_d = owner_q;
    if (!ownerReq && pickValid) begin
      owner_d = pickOwner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= BUS_OWNER_MASTER_0;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES ^ othersWait;
  assign bus_timeout        = 1'b0;
`endif

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = bus_owner_grant_n(owner_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, watchdog
// sequence and randomized traffic against a behavioural round-robin model.
module tb_bus_arbiter;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 256;
`endif

  logic clk = 1'b0;
  logic reset;
  logic m0Req, m1Req, m2Req, m3Req;
  logic m0Grnt, m1Grnt, m2Grnt, m3Grnt;
  logic busTimeout;

  int nCompared   = 0;
  int nMismatched = 0;

  int   mOwner = 0;
  int   mWait  = 0;
  logic mTo    = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] reqN;
    logic [3:0] expGrntN;
    logic       expTo;
    string      name;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req_     (m0Req),
    .m1_req_     (m1Req),
    .m2_req_     (m2Req),
    .m3_req_     (m3Req),
    .m0_grnt_    (m0Grnt),
    .m1_grnt_    (m1Grnt),
    .m2_grnt_    (m2Grnt),
    .m3_grnt_    (m3Grnt),
    .bus_timeout (busTimeout)
  );

  function automatic int nextRequester(input int owner, input logic [3:0] reqN);
    for (int k = 1; k <= 3; k++) begin
      if (!reqN[(owner + k) % 4]) return (owner + k) % 4;
    end
    return owner;
  endfunction

  // Behavioural model: one call per clock edge with the inputs sampled there.
  task automatic modelStep(input logic r, input logic [3:0] reqN);
    int waiting;
    mTo = 1'b0;
    waiting = 0;
    for (int i = 0; i < 4; i++) if (i != mOwner && !reqN[i]) waiting++;
    if (r) begin
      mOwner = 0;
      mWait  = 0;
    end else if (reqN[mOwner]) begin
      mOwner = nextRequester(mOwner, reqN);
      mWait  = 0;
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      if (waiting == 0) mWait = 0;
      else if (mWait == TO) begin
        mOwner = nextRequester(mOwner, reqN);
        mWait  = 0;
        mTo    = 1'b1;
      end else mWait++;
`endif
    end
  endtask

  function automatic logic [3:0] modelGrantN();
    logic [3:0] g;
    g = 4'hF;
    g[mOwner] = 1'b0;
    return g;
  endfunction

  task automatic applyStimulus(input logic r, input logic [3:0] reqN);
    reset = r;
    {m3Req, m2Req, m1Req, m0Req} = reqN;
    @(posedge clk);
    modelStep(r, reqN);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expG, input logic expT);
    logic [3:0] g;
    g = {m3Grnt, m2Grnt, m1Grnt, m0Grnt};
    nCompared++;
    if (g !== expG) begin
      nMismatched++;
      $display("[TB] FAIL %s grnt_: got %b want %b", name, g, expG);
    end
    nCompared++;
    if (busTimeout !== expT) begin
      nMismatched++;
      $display("[TB] FAIL %s bus_timeout: got %b want %b", name, busTimeout, expT);
    end
  endtask

  initial begin
    logic [3:0] rq;
    logic       rr;

    reset = 1'b1;
    {m3Req, m2Req, m1Req, m0Req} = 4'hF;

    // reqN / grant vectors are {m3,m2,m1,m0}, all active low
    vecs[0]  = '{1'b1, 4'b0000, 4'b1110, 1'b0, "reset_all_req"};
    vecs[1]  = '{1'b0, 4'b0000, 4'b1110, 1'b0, "m0_holds"};
    vecs[2]  = '{1'b0, 4'b0101, 4'b1101, 1'b0, "m0_release_to_m1"};
    vecs[3]  = '{1'b0, 4'b0101, 4'b1101, 1'b0, "m1_holds"};
    vecs[4]  = '{1'b0, 4'b0111, 4'b0111, 1'b0, "m1_release_to_m3"};
    vecs[5]  = '{1'b0, 4'b1010, 4'b1110, 1'b0, "m3_wrap_to_m0"};
    vecs[6]  = '{1'b0, 4'b0000, 4'b1110, 1'b0, "m0_holds_all_req"};
    vecs[7]  = '{1'b0, 4'b1011, 4'b1011, 1'b0, "m0_release_to_m2"};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1011, 1'b0, "m2_parked"};
    vecs[9]  = '{1'b0, 4'b1111, 4'b1011, 1'b0, "m2_parked_again"};
    vecs[10] = '{1'b0, 4'b1101, 4'b1101, 1'b0, "parked_to_m1"};
    vecs[11] = '{1'b0, 4'b0000, 4'b1101, 1'b0, "m1_holds_all_req"};
    vecs[12] = '{1'b0, 4'b0010, 4'b1011, 1'b0, "m1_rotate_to_m2"};
    vecs[13] = '{1'b0, 4'b0000, 4'b1011, 1'b0, "m2_holds"};
    vecs[14] = '{1'b1, 4'b0000, 4'b1110, 1'b0, "reset_mid_transfer"};
    vecs[15] = '{1'b0, 4'b1111, 4'b1110, 1'b0, "m0_parked"};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].reqN);
      checkOutput(vecs[i].name, vecs[i].expGrntN, vecs[i].expTo);
    end

    applyStimulus(1'b1, 4'hF);
    checkOutput("wd_reset", 4'b1110, 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b1110);
      checkOutput("wd_m0_alone", 4'b1110, 1'b0);
    end
    // m1 waits: handover with a single timeout pulse on the (TO+1)th edge
    for (int i = 0; i < TO + 3; i++) begin
      applyStimulus(1'b0, 4'b1100);
      if (i < TO) checkOutput("wd_m0_holds", 4'b1110, 1'b0);
      else if (i == TO) checkOutput("wd_forced_handover", 4'b1101, 1'b1);
      else checkOutput("wd_m1_after", 4'b1101, 1'b0);
    end
`else
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b0, 4'b1100);
      checkOutput("no_wd_m0_holds", 4'b1110, 1'b0);
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      rq = 4'($urandom);
      applyStimulus(rr, rq);
      checkOutput("random", modelGrantN(), mTo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
